// File: rtl/snake_pkg.sv
// Shared object codes, scanner state encoding and the flag priority encoder.
package snake_pkg;

    localparam int unsigned CODE_W = 3;

    typedef enum logic [CODE_W-1:0] {
        OBJ_EMPTY  = 3'd0,
        OBJ_BODY   = 3'd1,
        OBJ_HEAD   = 3'd2,
        OBJ_APPLE  = 3'd3,
        OBJ_BORDER = 3'd4
    } obj_code_t;

    // Scanner states kept as plain constants for compatibility with older tools.
    typedef logic [1:0] state_t;
    localparam state_t ST_INIT = 2'd0;
    localparam state_t ST_SCAN = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_EOF  = 2'd3;

    // Border wins over head, head over body, body over apple.
    function automatic obj_code_t encode_obj(input logic border, input logic head,
                                             input logic body, input logic apple);
        obj_code_t code;
        if (border)     code = OBJ_BORDER;
        else if (head)  code = OBJ_HEAD;
        else if (body)  code = OBJ_BODY;
        else if (apple) code = OBJ_APPLE;
        else            code = OBJ_EMPTY;
        return code;
    endfunction

endpackage

// File: rtl/grid_scan_counter.sv
// Raster x/y position counter for the playfield scan.
module grid_scan_counter #(
    parameter int unsigned GRID_W = 16,
    parameter int unsigned GRID_H = 12,
    parameter int unsigned XW     = $clog2(GRID_W),
    parameter int unsigned YW     = $clog2(GRID_H)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          advance,
    input  logic          clear,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last_cell
);
    localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    // Step one cell in raster order; clear has priority over advance.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (clear) begin
            x_q <= '0;
            y_q <= '0;
        end else if (advance) begin
            if (x_q == XMAX) begin
                x_q <= '0;
                y_q <= (y_q == YMAX) ? '0 : y_q + YW'(1);
            end else begin
                x_q <= x_q + XW'(1);
            end
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign last_cell = (x_q == XMAX) && (y_q == YMAX);

endmodule

// File: rtl/frame_diff_scanner.sv
// Scans the playfield, encodes each cell, and reports changed (or all) cells to the display.
module frame_diff_scanner
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W = 16,
    parameter int unsigned GRID_H = 12,
    parameter int unsigned CODE_W = snake_pkg::CODE_W,
    parameter int unsigned XW     = $clog2(GRID_W),
    parameter int unsigned YW     = $clog2(GRID_H)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              snakeBody,
    input  logic              snakeHead,
    input  logic              apple,
    input  logic              border,
    input  logic              mode_pb,
    input  logic              GameOver,
    input  logic              cmd_done,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic [CODE_W-1:0] obj_code,
    output logic              diff,
    output logic              init_cycle,
    output logic              en_update,
    output logic              sync_reset,
    output logic              full_mode
);
    localparam int unsigned CELLS = GRID_W * GRID_H;
    localparam int unsigned AW    = $clog2(CELLS);

    state_t state_q, state_d;
    logic   init_q, full_q, mode_req_q, armed_q, sync_q;
    logic   advance, clear, store_we, last_cell, report, restart;

    logic [CODE_W-1:0] store_q [CELLS];
    logic [AW-1:0]     addr;

    grid_scan_counter #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .XW     (XW),
        .YW     (YW)
    ) u_counter (
        .clk       (clk),
        .nrst      (nrst),
        .advance   (advance),
        .clear     (clear),
        .x         (x),
        .y         (y),
        .last_cell (last_cell)
    );

    assign obj_code = CODE_W'(encode_obj(border, snakeHead, snakeBody, apple));
    assign addr     = AW'(y) * AW'(GRID_W) + AW'(x);
    assign report   = init_q | full_q | (obj_code != store_q[addr]);

    // In WAIT a restart is only taken together with cmd_done so the display finishes its cell.
    assign restart  = GameOver & armed_q & ((state_q != ST_WAIT) | cmd_done);

    // Next state, counter control and code store write enable.
    always_comb begin
        state_d  = state_q;
        advance  = 1'b0;
        clear    = 1'b0;
        store_we = 1'b0;
        if (restart) begin
            state_d = ST_INIT;
            clear   = 1'b1;
        end else begin
            case (state_q)
                ST_INIT: state_d = ST_SCAN;
                ST_SCAN: begin
                    if (report) begin
                        store_we = 1'b1;
                        state_d  = ST_WAIT;
                    end else if (last_cell) begin
                        state_d = ST_EOF;
                    end else begin
                        advance = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cmd_done) begin
                        if (last_cell) begin
                            state_d = ST_EOF;
                        end else begin
                            advance = 1'b1;
                            state_d = ST_SCAN;
                        end
                    end
                end
                ST_EOF: begin
                    clear   = 1'b1;
                    state_d = ST_SCAN;
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    // FSM state, frame flags and restart arming.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_INIT;
            init_q     <= 1'b1;
            full_q     <= 1'b0;
            mode_req_q <= 1'b0;
            armed_q    <= 1'b1;
            sync_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= restart;
            if (restart) begin
                armed_q <= 1'b0;
            end else if (!GameOver) begin
                armed_q <= 1'b1;
            end
            if (restart) begin
                init_q <= 1'b1;
            end else if (state_q == ST_EOF) begin
                init_q <= 1'b0;
            end
            // A pending request (including a press in the EOF cycle itself) is applied at EOF.
            if (!restart && state_q == ST_EOF) begin
                full_q     <= full_q ^ (mode_req_q ^ mode_pb);
                mode_req_q <= 1'b0;
            end else if (mode_pb) begin
                mode_req_q <= ~mode_req_q;
            end
        end
    end

    // Previous-frame code store: bulk clear on restart, one write per reported cell.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < int'(CELLS); i++) store_q[i] <= '0;
        end else if (restart) begin
            for (int i = 0; i < int'(CELLS); i++) store_q[i] <= '0;
        end else if (store_we) begin
            store_q[addr] <= obj_code;
        end
    end

    assign diff       = (state_q == ST_WAIT);
    assign en_update  = (state_q == ST_EOF);
    assign init_cycle = init_q;
    assign full_mode  = full_q;
    assign sync_reset = sync_q;

endmodule
